// File: rtl/hash_result_scanner_if.sv
// Read-only memory port used by hash_result_scanner to fetch hash words
// from shared memory.
interface hash_result_scanner_if;
  logic        mem_clk;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  modport master (
    output mem_clk, mem_we, mem_addr, mem_write_data,
    input  mem_read_data
  );

  modport slave (
    input  mem_clk, mem_we, mem_addr, mem_write_data,
    output mem_read_data
  );
endinterface

// File: rtl/hash_result_scanner.sv
// Scans NUM_NONCES hash first-words from memory and reports winners against a
// target, plus the minimum hash and its nonce.
module hash_result_scanner #(
  parameter int unsigned NUM_NONCES = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [15:0]           result_addr,
  input  logic [31:0]           target,
  output logic                  done,
  output logic                  found,
  output logic [7:0]            first_nonce,
  output logic [8:0]            match_count,
  output logic [31:0]           min_hash,
  output logic [7:0]            min_nonce,
  hash_result_scanner_if.master mem
);

  typedef enum logic [1:0] {IDLE, READ, COMPLETE} state_t;

  localparam logic [7:0] LAST_IDX = 8'(NUM_NONCES - 1);
  localparam logic [8:0] LAST_CYC = 9'(NUM_NONCES);

  state_t      state_q, state_d;
  logic [15:0] base_q, base_d;
  logic [31:0] tgt_q, tgt_d;
  logic [7:0]  rd_idx_q, rd_idx_d;
  logic [8:0]  cyc_q, cyc_d;
  logic        done_q, done_d;
  logic        found_q, found_d;
  logic [7:0]  first_nonce_q, first_nonce_d;
  logic [8:0]  match_count_q, match_count_d;
  logic [31:0] min_hash_q, min_hash_d;
  logic [7:0]  min_nonce_q, min_nonce_d;
  logic [7:0]  cap_nonce;

  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    tgt_d         = tgt_q;
    rd_idx_d      = rd_idx_q;
    cyc_d         = cyc_q;
    done_d        = 1'b0;
    found_d       = found_q;
    first_nonce_d = first_nonce_q;
    match_count_d = match_count_q;
    min_hash_d    = min_hash_q;
    min_nonce_d   = min_nonce_q;
    cap_nonce     = 8'(cyc_q - 9'd1);

    case (state_q)
      IDLE: begin
        if (start) begin
          base_d        = result_addr;
          tgt_d         = target;
          found_d       = 1'b0;
          first_nonce_d = '0;
          match_count_d = '0;
          min_hash_d    = '1;
          min_nonce_d   = '0;
          rd_idx_d      = '0;
          cyc_d         = '0;
          state_d       = READ;
        end
      end
      READ: begin
        // Cycle c issues address min(c, N-1) and captures the word for c-1.
        if (rd_idx_q != LAST_IDX) rd_idx_d = rd_idx_q + 8'd1;
        cyc_d = cyc_q + 9'd1;
        if (cyc_q != 9'd0) begin
          if (mem.mem_read_data < tgt_q) begin
            match_count_d = match_count_q + 9'd1;
            if (!found_q) begin
              found_d       = 1'b1;
              first_nonce_d = cap_nonce;
            end
          end
          if (mem.mem_read_data < min_hash_q) begin
            min_hash_d  = mem.mem_read_data;
            min_nonce_d = cap_nonce;
          end
        end
        if (cyc_q == LAST_CYC) begin
          state_d = COMPLETE;
          done_d  = 1'b1;
        end
      end
      COMPLETE: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      base_q        <= '0;
      tgt_q         <= '0;
      rd_idx_q      <= '0;
      cyc_q         <= '0;
      done_q        <= 1'b0;
      found_q       <= 1'b0;
      first_nonce_q <= '0;
      match_count_q <= '0;
      min_hash_q    <= '1;
      min_nonce_q   <= '0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      tgt_q         <= tgt_d;
      rd_idx_q      <= rd_idx_d;
      cyc_q         <= cyc_d;
      done_q        <= done_d;
      found_q       <= found_d;
      first_nonce_q <= first_nonce_d;
      match_count_q <= match_count_d;
      min_hash_q    <= min_hash_d;
      min_nonce_q   <= min_nonce_d;
    end
  end

  assign done               = done_q;
  assign found              = found_q;
  assign first_nonce        = first_nonce_q;
  assign match_count        = match_count_q;
  assign min_hash           = min_hash_q;
  assign min_nonce          = min_nonce_q;
  assign mem.mem_clk        = clk;
  assign mem.mem_we         = 1'b0;
  assign mem.mem_write_data = '0;
  assign mem.mem_addr       = base_q + {8'h00, rd_idx_q};

endmodule

// File: tb/tb_hash_result_scanner.sv
// Directed and randomized scans of hash_result_scanner against a reference
// model that applies the win/minimum rules directly over the word list.
module tb_hash_result_scanner;
  localparam int unsigned N = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] result_addr = '0;
  logic [31:0] target = '0;
  logic        done, found;
  logic [7:0]  first_nonce, min_nonce;
  logic [8:0]  match_count;
  logic [31:0] min_hash;

  hash_result_scanner_if bus ();

  hash_result_scanner #(.NUM_NONCES(N)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .result_addr (result_addr),
    .target      (target),
    .done        (done),
    .found       (found),
    .first_nonce (first_nonce),
    .match_count (match_count),
    .min_hash    (min_hash),
    .min_nonce   (min_nonce),
    .mem         (bus.master)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:65535];
  always @(posedge bus.mem_clk) bus.mem_read_data <= mem[bus.mem_addr];

  int checks = 0;
  int errors = 0;
  logic [31:0] w [N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load_words(input logic [15:0] base);
    for (int i = 0; i < int'(N); i++) mem[16'(base + 16'(i))] = w[i];
  endtask

  task automatic check_results(input logic [31:0] tgt, input string tag);
    int cnt = 0;
    int first = -1;
    logic [31:0] mn = 32'hFFFF_FFFF;
    int mn_idx = 0;
    for (int i = 0; i < int'(N); i++) begin
      if (w[i] < tgt) begin
        cnt++;
        if (first < 0) first = i;
      end
      if (w[i] < mn) mn = w[i];
    end
    for (int i = int'(N) - 1; i >= 0; i--) if (w[i] == mn) mn_idx = i;
    chk({tag, ".found"},       32'(found),       32'(first >= 0));
    chk({tag, ".first_nonce"}, 32'(first_nonce), 32'((first >= 0) ? first : 0));
    chk({tag, ".match_count"}, 32'(match_count), 32'(cnt));
    chk({tag, ".min_hash"},    min_hash,         mn);
    chk({tag, ".min_nonce"},   32'(min_nonce),   32'(mn_idx));
  endtask

  task automatic run_scan(input logic [15:0] base, input logic [31:0] tgt,
                          input bit repulse, input string tag);
    load_words(base);
    @(negedge clk);
    result_addr = base;
    target      = tgt;
    start       = 1'b1;
    for (int c = 0; c <= int'(N); c++) begin
      @(negedge clk);
      if (c == 0) begin
        start       = 1'b0;
        result_addr = ~base;
        target      = ~tgt;
      end
      if (repulse) start = (c == 3);
      chk({tag, ".addr"}, 32'(bus.mem_addr),
          32'(16'(base + 16'((c < int'(N)) ? c : int'(N) - 1))));
      chk({tag, ".we"}, 32'(bus.mem_we), 32'd0);
      chk({tag, ".done_early"}, 32'(done), 32'd0);
    end
    start = 1'b0;
    @(negedge clk);
    chk({tag, ".done"}, 32'(done), 32'd1);
    chk({tag, ".wdata"}, bus.mem_write_data, 32'd0);
    check_results(tgt, tag);
    @(negedge clk);
    chk({tag, ".done_pulse"}, 32'(done), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk({tag, ".no_extra_done"}, 32'(done), 32'd0);
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, ".done"},        32'(done),        32'd0);
    chk({tag, ".found"},       32'(found),       32'd0);
    chk({tag, ".first_nonce"}, 32'(first_nonce), 32'd0);
    chk({tag, ".match_count"}, 32'(match_count), 32'd0);
    chk({tag, ".min_hash"},    min_hash,         32'hFFFF_FFFF);
    chk({tag, ".min_nonce"},   32'(min_nonce),   32'd0);
    chk({tag, ".mem_addr"},    32'(bus.mem_addr), 32'd0);
    chk({tag, ".mem_we"},      32'(bus.mem_we),   32'd0);
  endtask

  initial begin
    int saw_done;
    logic [31:0] t;
    for (int a = 0; a < 65536; a++) mem[a] = 32'hDEAD_0000 | 32'(a);

    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset_n = 1'b1;

    // Ascending words, five below target.
    for (int i = 0; i < int'(N); i++) w[i] = 32'h1000_0000 + 32'(i);
    run_scan(16'h0100, 32'h1000_0005, 1'b0, "ascend");

    // Single winner at nonce 9.
    for (int i = 0; i < int'(N); i++) w[i] = 32'hFFFF_FFF0;
    w[9] = 32'h0000_0ABC;
    run_scan(16'h0200, 32'h0000_1000, 1'b0, "single");

    // target 0: no winners, tied minimum resolves to the lower nonce.
    for (int i = 0; i < int'(N); i++) w[i] = 32'h9000_0000;
    w[3] = 32'h8000_0000;
    w[7] = 32'h8000_0000;
    run_scan(16'h0300, 32'h0000_0000, 1'b0, "tgt_zero");

    // Address wrap with start re-pulsed mid-read.
    for (int i = 0; i < int'(N); i++) w[i] = 32'(i * 7 + 3);
    run_scan(16'hFFF8, 32'h0000_0020, 1'b1, "wrap_repulse");

    // target all-ones: everything but all-ones words wins.
    for (int i = 0; i < int'(N); i++) w[i] = (i % 3 == 0) ? 32'hFFFF_FFFF : 32'($urandom);
    run_scan(16'h4000, 32'hFFFF_FFFF, 1'b0, "tgt_ones");

    // Reset during READ cycle 6.
    for (int i = 0; i < int'(N); i++) w[i] = 32'(i);
    load_words(16'h0500);
    @(negedge clk);
    result_addr = 16'h0500;
    target      = 32'h0000_0008;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_reset_values("midreset");
    @(negedge clk);
    reset_n = 1'b1;
    saw_done = 0;
    for (int c = 0; c < int'(N) + 4; c++) begin
      @(negedge clk);
      if (done) saw_done++;
    end
    chk("midreset.no_done", 32'(saw_done), 32'd0);
    chk("midreset.idle_addr", 32'(bus.mem_addr), 32'd0);
    run_scan(16'h0600, 32'h0000_0008, 1'b0, "after_reset");

    // Randomized scans over a small value set so ties and boundaries occur.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < int'(N); i++)
        w[i] = (32'($urandom_range(0, 7)) << 28) | 32'($urandom_range(0, 3));
      t = (r == 0) ? 32'h0000_0000 : (32'($urandom_range(0, 8)) << 28);
      run_scan(16'($urandom), t, 1'b0, $sformatf("rand%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
